// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the selects of a downstream 16-way mux.
// Optional grant-hold limit enabled by defining MUX_RR_ARBITER_TIMEOUT_EN.
module mux_rr_arbiter #(
    parameter int unsigned NINPUTS  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel_bin,
    output logic [15:0] sel_onehot,
    output logic        grant_valid,
    output logic        grant_pulse,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  last_q, last_d;
    logic [15:0] onehot_q, onehot_d;
    logic        valid_q, valid_d;
    logic        pulse_q, pulse_d;

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    logic [7:0]  hold_q, hold_d;
    logic        timeout_q, timeout_d;
`endif

    logic [3:0]  winner;
    logic        found;
    int unsigned idx;

    // Search starts one past the last winner; only indices below NINPUTS are visited.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NINPUTS; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NINPUTS) begin
                idx = idx - NINPUTS;
            end
            if (!found && req[idx[3:0]]) begin
                found  = 1'b1;
                winner = idx[3:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;
        last_d   = last_q;
        valid_d  = valid_q;
        pulse_d  = 1'b0;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    sel_d    = winner;
                    onehot_d = 16'd1 << winner;
                    last_d   = winner;
                    valid_d  = 1'b1;
                    pulse_d  = 1'b1;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                hold_d = hold_q + 8'd1;
`endif
                // A voluntary release outranks a forced one in the same cycle.
                if (done || !req[sel_q]) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                end
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = RELEASE;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            onehot_q <= '0;
            last_q   <= 4'(NINPUTS - 1);
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign sel_bin     = sel_q;
    assign sel_onehot  = onehot_q;
    assign grant_valid = valid_q;
    assign grant_pulse = pulse_q;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vectors plus a cycle model
// compared against the outputs on every falling edge.
module tb_mux_rr_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [3:0]  sel_bin;
    logic [15:0] sel_onehot;
    logic        grant_valid;
    logic        grant_pulse;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.NINPUTS(N), .MAX_HOLD(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .sel_bin    (sel_bin),
        .sel_onehot (sel_onehot),
        .grant_valid(grant_valid),
        .grant_pulse(grant_pulse),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a grant is "held" for some age, followed by a
    // one-cycle release and one idle cycle in which arbitration happens.
    bit m_ok      = 1'b0;
    bit m_holding = 1'b0;
    bit m_rel     = 1'b0;
    int m_age     = 0;
    int m_sel     = 0;
    int m_last    = N - 1;
    bit m_valid   = 1'b0;
    bit m_pulse   = 1'b0;
    bit m_to      = 1'b0;
    bit m_sel_set = 1'b0;

    function automatic int pick(input logic [15:0] r, input int last);
        for (int o = 1; o <= N; o++) begin
            int c;
            c = (last + o) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_ok = 1'b1; m_holding = 1'b0; m_rel = 1'b0; m_age = 0;
            m_sel = 0; m_last = N - 1; m_valid = 1'b0; m_pulse = 1'b0;
            m_to = 1'b0; m_sel_set = 1'b0;
        end else if (m_holding) begin
            m_pulse = 1'b0;
            m_age   = m_age + 1;
            if (done || !req[m_sel]) begin
                m_holding = 1'b0; m_rel = 1'b1; m_valid = 1'b0;
            end else if (TO_EN && m_age == HOLD) begin
                m_holding = 1'b0; m_rel = 1'b1; m_valid = 1'b0; m_to = 1'b1;
            end
        end else if (m_rel) begin
            m_rel = 1'b0; m_to = 1'b0;
        end else begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_holding = 1'b1; m_age = 0; m_sel = w; m_last = w;
                m_valid = 1'b1; m_pulse = 1'b1; m_sel_set = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_sel_bin", 16'(sel_bin), 16'(m_sel));
            chk("model_sel_onehot", sel_onehot, m_sel_set ? (16'd1 << m_sel) : 16'd0);
            chk("model_grant_valid", 16'(grant_valid), 16'(m_valid));
            chk("model_grant_pulse", 16'(grant_pulse), 16'(m_pulse));
            chk("model_timeout", 16'(timeout), 16'(m_to));
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int low;
        int bad;
        int seq [5] = '{0, 1, 2, 3, 0};

        // Reset state
        tick(); tick();
        chk("rst_sel_bin", 16'(sel_bin), 16'h0);
        chk("rst_onehot", sel_onehot, 16'h0);
        chk("rst_valid", 16'(grant_valid), 16'h0);
        chk("rst_pulse", 16'(grant_pulse), 16'h0);
        chk("rst_timeout", 16'(timeout), 16'h0);
        rst_n = 1'b1;
        tick();

        // Rotation 0,1,2,3,0 with done pulsed on every grant
        req = 16'h000F;
        tick();
        chk("rot_latency", 16'(grant_valid), 16'h1);
        for (int i = 0; i < 5; i++) begin
            chk("rot_sel", 16'(sel_bin), 16'(seq[i]));
            chk("rot_pulse_first", 16'(grant_pulse), 16'h1);
            tick();
            chk("rot_pulse_once", 16'(grant_pulse), 16'h0);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rot_release_sel", 16'(sel_bin), 16'(seq[i]));
            if (i < 4) begin
                low = 0;
                while (!grant_valid && low < 8) begin
                    low++;
                    tick();
                end
                // one RELEASE cycle plus the IDLE arbitration cycle
                chk("rot_low_gap", 16'(low), 16'd2);
            end
        end
        req = 16'h0000;
        tick(); tick();

        // Wrap past NINPUTS-1 after last=2
        req = 16'h0004;
        tick();
        chk("last2_sel", 16'(sel_bin), 16'd2);
        req = 16'h0000;
        tick(); tick();
        req = 16'h0003;
        tick();
        chk("wrap_sel", 16'(sel_bin), 16'd0);
        chk("wrap_onehot", sel_onehot, 16'h0001);
        req = 16'h0000;
        tick(); tick();

        // Out-of-range request bits ignored
        req = 16'hFFF0;
        tick(); tick(); tick();
        chk("oor_no_grant", 16'(grant_valid), 16'h0);
        req = 16'h0000;

        // Holder withdraws without done
        req = 16'h0002;
        tick();
        chk("wd_sel", 16'(sel_bin), 16'd1);
        tick();
        req = 16'h0000;
        tick();
        chk("wd_release_valid", 16'(grant_valid), 16'h0);
        chk("wd_release_sel", 16'(sel_bin), 16'd1);
        tick();
        chk("wd_idle_sel", 16'(sel_bin), 16'd1);

        // done and req drop together count once
        req = 16'h0001;
        tick();
        chk("both_sel", 16'(sel_bin), 16'd0);
        req = 16'h0000; done = 1'b1;
        tick();
        done = 1'b0;
        tick(); tick();
        chk("both_single", 16'(grant_valid), 16'h0);

        // Sole requester equal to last is re-granted; a late request waits
        req = 16'h0001;
        tick();
        chk("regrant_sel", 16'(sel_bin), 16'd0);
        req = 16'h0009; done = 1'b1;
        tick();
        done = 1'b0;
        tick(); tick();
        chk("pending_sel", 16'(sel_bin), 16'd3);
        chk("pending_valid", 16'(grant_valid), 16'h1);
        req = 16'h0000;
        tick(); tick();

        // Reset in the third GRANT cycle aborts the grant
        req = 16'h0004;
        tick();
        chk("abort_sel", 16'(sel_bin), 16'd2);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("abort_sel0", 16'(sel_bin), 16'h0);
        chk("abort_onehot0", sel_onehot, 16'h0);
        chk("abort_valid0", 16'(grant_valid), 16'h0);
        chk("abort_timeout0", 16'(timeout), 16'h0);
        rst_n = 1'b1; req = 16'h0006;
        tick();
        chk("post_rst_sel", 16'(sel_bin), 16'd1);
        chk("post_rst_onehot", sel_onehot, 16'h0002);
        req = 16'h0000;
        tick(); tick();

        // Hold limit
        req = 16'h0001;
        tick();
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            chk("to_hold_valid", 16'(grant_valid), 16'h1);
            tick();
        end
        chk("to_hold_last", 16'(grant_valid), 16'h1);
        tick();
        chk("to_pulse", 16'(timeout), 16'h1);
        chk("to_release_valid", 16'(grant_valid), 16'h0);
        tick();
        chk("to_pulse_end", 16'(timeout), 16'h0);
        tick();
        chk("to_regrant", 16'(grant_valid), 16'h1);
        chk("to_regrant_sel", 16'(sel_bin), 16'd0);
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("to_done_priority", 16'(timeout), 16'h0);
`else
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (!grant_valid || timeout) bad++;
            tick();
        end
        chk("hold_forever", 16'(bad), 16'd0);
`endif
        req = 16'h0000;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
